// File: rtl/tioe1_pkg.sv
// Shared constants and types for the tioe1 registered 4-input Boolean function.
package tioe1_pkg;

    localparam int unsigned IdxWidth = 4;
    localparam int unsigned TableSize = 1 << IdxWidth;

    // Default function: 1 for the 4-bit primes {2,3,5,7,11,13}
    localparam logic [TableSize-1:0] DefaultTruthTable = 16'h28AC;

    typedef logic [IdxWidth-1:0] idx_t;

endpackage

// File: rtl/tioe1_lut.sv
// Purely combinational 16:1 lookup: returns bit idx of the supplied table.
module tioe1_lut
    import tioe1_pkg::*;
(
    input  idx_t                   idx_i,
    input  logic [TableSize-1:0]   table_i,
    output logic                   bit_o
);

    assign bit_o = table_i[idx_i];

endmodule

// File: rtl/tioe1.sv
// Registered Boolean function F = TRUTH_TABLE[{A,B,C,D}] with one cycle of latency.
module tioe1
    import tioe1_pkg::*;
#(
    parameter logic [TableSize-1:0] TRUTH_TABLE = DefaultTruthTable
) (
    input  logic clk,
    input  logic rst,
    output logic F,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D
);

    idx_t idx;
    logic f_d;
    logic f_q;

    assign idx = {A, B, C, D};

    tioe1_lut u_lut (
        .idx_i   (idx),
        .table_i (TRUTH_TABLE),
        .bit_o   (f_d)
    );

    // Reset clears F without waiting for a clock edge; any pending result is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q <= 1'b0;
        end else begin
            f_q <= f_d;
        end
    end

    assign F = f_q;

endmodule

// File: tb/tb_tioe1.sv
// Scoreboard bench for tioe1: default table (primes) and a 16'h0001 override instance.
module tb_tioe1;

    logic clk;
    logic rst;
    logic A, B, C, D;
    logic f_main;
    logic f_ovr;

    typedef struct {
        logic [3:0] idx;
        logic       main;
        logic       ovr;
    } exp_t;

    exp_t q[$];
    logic mon_en;
    logic last_main;
    logic last_ovr;
    int   checks;
    int   errors;

    tioe1 u_dut (
        .clk (clk),
        .rst (rst),
        .F   (f_main),
        .A   (A),
        .B   (B),
        .C   (C),
        .D   (D)
    );

    tioe1 #(
        .TRUTH_TABLE (16'h0001)
    ) u_dut_ovr (
        .clk (clk),
        .rst (rst),
        .F   (f_ovr),
        .A   (A),
        .B   (B),
        .C   (C),
        .D   (D)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: default table is "idx is a 4-bit prime"; override is "idx is zero".
    function automatic logic is_prime(input int v);
        return v inside {2, 3, 5, 7, 11, 13};
    endfunction

    function automatic logic is_zero(input int v);
        return v == 0;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic [3:0] idx);
        exp_t e;
        {A, B, C, D} = idx;
        e.idx  = idx;
        e.main = is_prime(int'(idx));
        e.ovr  = is_zero(int'(idx));
        q.push_back(e);
        last_main = e.main;
        last_ovr  = e.ovr;
    endtask

    // Monitor: one expected entry per rising edge while enabled.
    always @(posedge clk) begin
        if (mon_en) begin
            exp_t e;
            #1;
            if (q.size() == 0) begin
                check("scoreboard_underflow", 1'b1, 1'b0);
            end else begin
                e = q.pop_front();
                check($sformatf("main_idx%0d", e.idx), f_main, e.main);
                check($sformatf("ovr_idx%0d", e.idx), f_ovr, e.ovr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        mon_en    = 1'b0;
        last_main = 1'b0;
        last_ovr  = 1'b0;
        rst       = 1'b1;
        {A, B, C, D} = 4'b1101;

        // Reset with a prime index applied: F stays 0 across edges.
        #1;
        check("reset_immediate", f_main, 1'b0);
        check("reset_immediate_ovr", f_ovr, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", f_main, 1'b0);
            check("reset_hold_ovr", f_ovr, 1'b0);
            {A, B, C, D} = (i == 0) ? 4'b0000 : 4'b0101;
        end

        // Sweep 0,1,2 right after release.
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        apply(4'd0);
        @(negedge clk) apply(4'd1);
        @(negedge clk) apply(4'd2);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk) apply(4'(i));
        end

        // Glitches on D between edges with C=1, A=B=0: only the value at the edge counts.
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            A = 1'b0; B = 1'b0; C = 1'b1; D = 1'b0;
            #1 check("glitch_hold_a", f_main, last_main);
            D = 1'b1;
            #1 check("glitch_hold_b", f_main, last_main);
            D = 1'b0;
            #1 check("glitch_hold_ovr", f_ovr, last_ovr);
            apply((g == 0) ? 4'b0011 : 4'b0010);
        end

        repeat (40) begin
            @(negedge clk) apply(4'($urandom_range(0, 15)));
        end

        @(negedge clk);
        mon_en = 1'b0;

        // Mid-operation reset pulse between edges.
        {A, B, C, D} = 4'b0101;
        @(posedge clk);
        #1;
        check("midrst_before", f_main, 1'b1);
        check("midrst_before_ovr", f_ovr, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("midrst_async", f_main, 1'b0);
        rst = 1'b0;
        #1 check("midrst_released_no_edge", f_main, 1'b0);
        @(posedge clk);
        #1;
        check("midrst_recover", f_main, 1'b1);
        check("midrst_recover_ovr", f_ovr, 1'b0);

        check("queue_drained", q.size() == 0, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tioe1.md
TIOE1 -- requirements
Module: tioe1

Interface
REQ-001 Parameter: TRUTH_TABLE, default 16'h28AC, 16-bit table where bit i is the value of F for input index i = {A,B,C,D} (A = MSB).
REQ-002 Port: clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: F  output  1  registered Boolean function result.
REQ-005 Port: A  input  1  index bit 3 (MSB).
REQ-006 Port: B  input  1  index bit 2.
REQ-007 Port: C  input  1  index bit 1.
REQ-008 Port: D  input  1  index bit 0 (LSB).
REQ-009 Positional order after clk, rst SHALL be F, A, B, C, D; benches SHALL connect ports by name.
REQ-010 The design SHALL have one clock (clk) and one reset (rst); reset is asynchronous and active-high.

Function
REQ-011 The design SHALL form index idx = {A,B,C,D} as a 4-bit unsigned value, 0..15.
REQ-012 The design SHALL compute next_F = TRUTH_TABLE[idx] combinationally.
REQ-013 F SHALL register next_F on each rising clk edge; latency is exactly 1 cycle from input change to F update.
REQ-014 With the default table, F SHALL be 1 exactly for idx in {2,3,5,7,11,13} (4-bit primes) and 0 otherwise.
REQ-015 Inputs SHALL be sampled only at clk rising edges; input changes between edges SHALL NOT affect F until the next edge.
REQ-016 Simultaneous changes on several inputs SHALL be treated as one new index at the next edge; there are no intermediate results.
REQ-017 The design SHALL have no handshake; a new result is produced every cycle (throughput 1/cycle).
REQ-018 The design SHALL contain no state beyond the F register; there are no overflow or wrap conditions.

Reset
REQ-019 Asserting rst SHALL force F = 0 immediately, independent of clk.
REQ-020 While rst is high, F SHALL remain 0 regardless of A..D.
REQ-021 After rst deasserts, the first rising clk edge SHALL load TRUTH_TABLE[idx] into F.
REQ-022 Reset asserted mid-operation SHALL discard the pending result; no recovery cycle is required.

Structure
REQ-023 Shared package tioe1_pkg SHALL hold:
- the default TRUTH_TABLE constant 16'h28AC;
- the index width constant (4);
- the index typedef (4-bit unsigned).
REQ-024 Sub-module tioe1_lut SHALL be a purely combinational 16:1 lookup (idx, table -> bit), instantiated once; the register SHALL live in tioe1.

Verification
REQ-025 Reset: assert rst with A..D = 1101 -> F = 0 immediately and through all edges while rst is high.
REQ-026 Sweep: after reset, drive idx 0000, 0001, 0010 one per cycle -> F = 0, 0, 1 one cycle after each.
REQ-027 Exhaustive: apply all 16 indices -> F matches 16'h28AC bitwise with 1-cycle latency (e.g. 1011 -> 1, 1111 -> 0).
REQ-028 Mid-cycle glitch: toggle D between edges with C = 1, A = B = 0 -> F changes only at the edge, reflecting the value at that edge.
REQ-029 Mid-operation reset: hold idx 0101 (F = 1), then pulse rst between edges -> F drops to 0 asynchronously and returns to 1 on the first edge after release.
REQ-030 Parameter override: TRUTH_TABLE = 16'h0001 -> F = 1 only for idx 0000.
